// File: rtl/sprite_x_store.sv
// -----------------------------------------------------------------------------
// sprite_x_store
//
// Sprite slot store for the PPU line pipeline. During OAM scan, scanned sprite
// entries (X, OAM index, line offset) fill slots in arrival order. During pixel
// transfer, every valid slot is compared against the current pixel X. The
// lowest-numbered hit is latched and presented to the fetcher. It is held
// until fetch_done, and then that slot is retired. This way, sprites that
// share an X are served one at a time in slot order.
//
// Ports:
//   clk, nreset              clock (rising edge), asynchronous active-low reset
//   line_start               clears slots, count, overflow and any held match
//   scan_valid/x/id/line     write strobe and payload of one scanned sprite
//   pix_en, pix_x            matching enable and current pixel X
//   fetch_done               fetcher consumed the presented match
//   count, full, overflow    slots written this line, store full, sticky overflow
//   match_valid/slot/id/line presented match
// -----------------------------------------------------------------------------
module sprite_x_store #(
   parameter int SLOTS = 10,
   parameter int XW    = 8,
   parameter int IDW   = 6,
   parameter int LW    = 4,
   parameter int SW    = 4
) (
   input  logic           clk,
   input  logic           nreset,
   input  logic           line_start,
   input  logic           scan_valid,
   input  logic [XW-1:0]  scan_x,
   input  logic [IDW-1:0] scan_id,
   input  logic [LW-1:0]  scan_line,
   input  logic           pix_en,
   input  logic [XW-1:0]  pix_x,
   input  logic           fetch_done,
   output logic [SW-1:0]  count,
   output logic           full,
   output logic           overflow,
   output logic           match_valid,
   output logic [SW-1:0]  match_slot,
   output logic [IDW-1:0] match_id,
   output logic [LW-1:0]  match_line
);

   localparam logic [0:0]    ST_IDLE = 1'b0;
   localparam logic [0:0]    ST_HOLD = 1'b1;
   localparam logic [SW-1:0] SLOTS_C = SW'(SLOTS);

   // Control state (reset)
   logic [SLOTS-1:0] valid_q, valid_d;
   logic [SW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic [0:0]       state_q, state_d;
   logic [SW-1:0]    match_slot_q, match_slot_d;
   logic [IDW-1:0]   match_id_q, match_id_d;
   logic [LW-1:0]    match_line_q, match_line_d;

   // Slot payload (no reset; qualified by valid_q)
   logic [XW-1:0]    slot_x_q[SLOTS], slot_x_d[SLOTS];
   logic [IDW-1:0]   slot_id_q[SLOTS], slot_id_d[SLOTS];
   logic [LW-1:0]    slot_line_q[SLOTS], slot_line_d[SLOTS];

   // Priority-encoded compare result
   logic             hit_any;
   logic [SW-1:0]    win_slot;
   logic [IDW-1:0]   win_id;
   logic [LW-1:0]    win_line;

   assign full = (count_q == SLOTS_C);

   // Compare uses registered valid bits only, so a slot written on this edge
   // cannot match until the following cycle. The scan runs from the top slot
   // down, so the lowest hit is the one that sticks.
   always_comb begin
      hit_any  = 1'b0;
      win_slot = '0;
      win_id   = '0;
      win_line = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (valid_q[i] && pix_en && (slot_x_q[i] == pix_x)) begin
            hit_any  = 1'b1;
            win_slot = SW'(i);
            win_id   = slot_id_q[i];
            win_line = slot_line_q[i];
         end
      end
   end

   always_comb begin
      valid_d      = valid_q;
      count_d      = count_q;
      overflow_d   = overflow_q;
      state_d      = state_q;
      match_slot_d = match_slot_q;
      match_id_d   = match_id_q;
      match_line_d = match_line_q;
      slot_x_d     = slot_x_q;
      slot_id_d    = slot_id_q;
      slot_line_d  = slot_line_q;

      if (line_start) begin
         valid_d    = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         state_d    = ST_IDLE;
      end else begin
         if (state_q == ST_HOLD) begin
            // Outputs stay frozen until the fetcher acknowledges; then the
            // presented slot is retired so the next equal-X slot can win.
            if (fetch_done) begin
               for (int i = 0; i < SLOTS; i++) begin
                  if (SW'(i) == match_slot_q) valid_d[i] = 1'b0;
               end
               state_d = ST_IDLE;
            end
         end else if (hit_any) begin
            state_d      = ST_HOLD;
            match_slot_d = win_slot;
            match_id_d   = win_id;
            match_line_d = win_line;
         end

         // The write slot is always >= count_q, so it never collides with
         // the retired slot, which is always < count_q.
         if (scan_valid) begin
            if (full) begin
               overflow_d = 1'b1;
            end else begin
               for (int i = 0; i < SLOTS; i++) begin
                  if (SW'(i) == count_q) begin
                     valid_d[i]     = 1'b1;
                     slot_x_d[i]    = scan_x;
                     slot_id_d[i]   = scan_id;
                     slot_line_d[i] = scan_line;
                  end
               end
               count_d = count_q + SW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         valid_q      <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         state_q      <= ST_IDLE;
         match_slot_q <= '0;
         match_id_q   <= '0;
         match_line_q <= '0;
      end else begin
         valid_q      <= valid_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         state_q      <= state_d;
         match_slot_q <= match_slot_d;
         match_id_q   <= match_id_d;
         match_line_q <= match_line_d;
      end
   end

   always_ff @(posedge clk) begin
      slot_x_q    <= slot_x_d;
      slot_id_q   <= slot_id_d;
      slot_line_q <= slot_line_d;
   end

   assign count       = count_q;
   assign overflow    = overflow_q;
   assign match_valid = (state_q == ST_HOLD);
   assign match_slot  = match_slot_q;
   assign match_id    = match_id_q;
   assign match_line  = match_line_q;

endmodule
